// File: rtl/alu_hs_pkg.sv
// Shared opcode and state definitions for the iterative handshake ALU.
package alu_hs_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_SLTU = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_MULS = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    HOLD = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULS);
  endfunction

endpackage

// File: rtl/alu_iterative_hs_if.sv
// Operand/result handshake bundle between producer, ALU and consumer.
interface alu_iterative_hs_if
  import alu_hs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [OPCODE_W-1:0]   opcode;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WIDTH-1:0]    result;
  logic                  flag_zero;
  logic                  flag_carry;
  logic                  err;
  logic                  busy;

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_carry, err, busy
  );

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_carry, err, busy
  );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier, one partial product per cycle over WIDTH cycles.
// Signed mode multiplies magnitudes and negates when operand signs differ.
module alu_shift_add_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic             neg_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_d;

  // Unsigned magnitude of the most-negative value is itself, so no special case.
  always_comb begin
    a_neg   = signed_mode & a[WIDTH-1];
    b_neg   = signed_mode & b[WIDTH-1];
    a_mag   = a_neg ? WIDTH'(-a) : a;
    b_mag   = b_neg ? WIDTH'(-b) : b;
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    done    = run_q && (cnt_q == CW'(WIDTH - 1));
    product = neg_q ? PW'(-acc_d) : acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= PW'(a_mag);
      acc_q    <= '0;
      mplier_q <= b_mag;
      neg_q    <= a_neg ^ b_neg;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iterative_hs.sv
// Handshake ALU: FSM, operand latch, single-cycle ops and result hold register;
// multiplies are delegated to the iterative shift-add unit.
module alu_iterative_hs
  import alu_hs_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_iterative_hs_if.slave  bus
);
  localparam int unsigned PW = 2 * WIDTH;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [PW-1:0]       res_q, res_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                mul_start;

  logic [PW-1:0]       exec_res;
  logic                exec_carry;
  logic                exec_err;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    diff;
  logic                mul_done;
  logic [PW-1:0]       mul_product;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (mul_start),
    .signed_mode (bus.opcode == OP_MULS),
    .a           (bus.a),
    .b           (bus.b),
    .done        (mul_done),
    .product     (mul_product)
  );

  // Single-cycle datapath on latched operands.
  always_comb begin
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_err   = 1'b0;
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff       = a_q - b_q;
    if (op_q > OP_LAST) begin
      exec_err = 1'b1;
    end else begin
      case (op_q)
        OP_ADD: begin
          exec_res   = PW'(sum);
          exec_carry = sum[WIDTH];
        end
        OP_SUB: begin
          exec_res   = PW'(diff);
          exec_carry = a_q < b_q;
        end
        OP_AND:  exec_res = PW'(a_q & b_q);
        OP_OR:   exec_res = PW'(a_q | b_q);
        OP_XOR:  exec_res = PW'(a_q ^ b_q);
        OP_SLT:  exec_res = PW'($signed(a_q) < $signed(b_q));
        OP_SLTU: exec_res = PW'(a_q < b_q);
        default: exec_res = '0;
      endcase
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d  = bus.a;
          b_d  = bus.b;
          op_d = bus.opcode;
          if (is_mul_op(bus.opcode)) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        res_d       = exec_res;
        zero_d      = (exec_res == '0);
        carry_d     = exec_carry;
        err_d       = exec_err;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      MUL: begin
        if (mul_done) begin
          res_d       = mul_product;
          zero_d      = (mul_product == '0);
          carry_d     = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = res_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_alu_iterative_hs.sv
// Randomized self-checking bench for alu_iterative_hs against an arithmetic reference model.
module tb_alu_iterative_hs;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  typedef struct packed {
    logic [PW-1:0] res;
    logic          zero;
    logic          carry;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_iterative_hs_if #(.WIDTH(W)) bus ();

  alu_iterative_hs #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int op, input longint a, input longint b);
    longint m;
    longint sa;
    longint sb;
    longint r;
    exp_t   e;
    m  = longint'(1) << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    e.carry = 1'b0;
    e.err   = 1'b0;
    case (op)
      0: begin r = a + b; e.carry = (r >= m); end
      1: begin r = (a - b + m) % m; e.carry = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      7: r = a * b;
      8: begin r = sa * sb; if (r < 0) r = r + m * m; end
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.res  = PW'(r);
    e.zero = (r == 0);
    return e;
  endfunction

  // One transaction: accept, wait for result (edges counted including the accepting edge),
  // optionally hold off the consumer, then release.
  task automatic run_op(input int op, input int av, input int bv, input int hold, input string tag);
    exp_t e;
    int   lat;
    int   bad;
    int   exp_lat;
    e       = model(op, longint'(av), longint'(bv));
    exp_lat = (op == 7 || op == 8) ? W + 1 : 2;
    bus.a         = W'(av);
    bus.b         = W'(bv);
    bus.opcode    = 4'(op);
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    check({tag, ":in_ready"}, 64'(bus.in_ready), 64'(1));
    tick();
    lat = 1;
    bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.busy || bus.in_ready) bad++;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.opcode   = 4'($urandom);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":busy_run"}, 64'(bad), 64'(0));
    check({tag, ":result"}, 64'(bus.result), 64'(e.res));
    check({tag, ":flags"}, 64'({bus.flag_zero, bus.flag_carry, bus.err}),
          64'({e.zero, e.carry, e.err}));
    check({tag, ":hold_busy"}, 64'({bus.busy, bus.in_ready}), 64'(2'b10));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ":bp_state"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b101));
      check({tag, ":bp_result"}, 64'(bus.result), 64'(e.res));
      check({tag, ":bp_flags"}, 64'({bus.flag_zero, bus.flag_carry, bus.err}),
            64'({e.zero, e.carry, e.err}));
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, ":release"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'(3'b010));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":outs"},
          64'({bus.out_valid, bus.flag_zero, bus.flag_carry, bus.err, bus.busy, bus.in_ready}),
          64'(6'b000001));
    check({tag, ":result"}, 64'(bus.result), 64'(0));
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    run_op(0, 'hFF, 'h01, 0, "add_carry");
    run_op(1, 'h03, 'h05, 0, "sub_borrow");
    run_op(1, 'h05, 'h05, 0, "sub_zero");
    run_op(7, 'hFF, 'hFF, 0, "mul_ff");
    run_op(8, 'h80, 'hFF, 0, "muls_80_ff");
    run_op(8, 'h80, 'h80, 0, "muls_80_80");
    run_op(8, 'h7F, 'h80, 0, "muls_7f_80");
    run_op(5, 'h80, 'h01, 0, "slt");
    run_op(6, 'h80, 'h01, 0, "sltu");
    run_op(0, 'h12, 'h34, 5, "add_bp");
    run_op(2, 'hF0, 'h3C, 0, "and_b2b");
    run_op(12, 'h55, 'hAA, 0, "illegal_c");

    // Reset during the fourth multiply cycle abandons the operation.
    bus.a         = 8'h9D;
    bus.b         = 8'h37;
    bus.opcode    = 4'd7;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("mid_reset:no_emit", 64'(seen), 64'(0));
    run_op(8, 'hFE, 'h03, 1, "after_reset");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_iterative_hs.md
Name: alu_iterative_hs

Overview:
Parametrised successor to the Day-6 multi-cycle handshake ALU.
- Accepts one operation per valid/ready transfer and executes it.
- Single-cycle ops complete in one EXEC cycle. Unsigned and signed multiplies run on an iterative shift-add unit over WIDTH cycles.
- Adds output backpressure (out_ready), status flags and illegal-opcode reporting.
- Sits between an operand producer and a result consumer in the day-series datapath.

Parameters:
WIDTH, 8, operand width in bits (legal range 4..32); result width is 2*WIDTH.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  producer has an operation
in_ready  out  1  block can accept; equals (state==IDLE)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
opcode  in  4  operation select
out_valid  out  1  result/flags valid; held until out_ready
out_ready  in  1  consumer accepts result
result  out  2*WIDTH  operation result
flag_zero  out  1  result == 0
flag_carry  out  1  ADD carry-out / SUB borrow; 0 for other ops
err  out  1  opcode was illegal
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - out_valid, result, flag_zero, flag_carry, err and busy are all 0.
  - Operand registers and multiplier counter are cleared.
  - Reset mid-operation abandons the operation; nothing is ever emitted for it.
- States: IDLE, EXEC, MUL, HOLD.
  - IDLE: in_ready=1. On in_valid, latch a, b and opcode, then go to MUL if opcode is MUL/MULS, else EXEC. Inputs are sampled only at this transfer; later changes have no effect.
  - EXEC: one cycle. Compute, register result and flags, go to HOLD.
  - MUL: iteration counter runs 0..WIDTH-1 with one shift-add step per cycle. On the count WIDTH-1 edge, register the product and flags and go to HOLD.
  - HOLD: out_valid=1. result, flags and err stay stable until out_ready=1. Then out_valid drops on the next edge and the block returns to IDLE.
- Latency:
  - Single-cycle op: out_valid rises 2 edges after the accepting edge.
  - Multiply: out_valid rises WIDTH+1 edges after the accepting edge.
- Throughput: no new accept while EXEC, MUL or HOLD; in_ready is low and in_valid is ignored.
- out_ready while out_valid=0 is ignored.
- Opcodes (results zero-extended to 2*WIDTH unless stated):
  - 0 ADD: result[WIDTH:0] = a+b; flag_carry = bit WIDTH.
  - 1 SUB: result[WIDTH-1:0] = a-b mod 2^WIDTH; flag_carry = (a<b unsigned).
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SLT: signed a<b gives 1, else 0.
  - 6 SLTU: unsigned a<b gives 1, else 0.
  - 7 MUL: unsigned full 2*WIDTH product.
  - 8 MULS: signed 2*WIDTH two's-complement product. Multiply magnitudes, then negate if the operand signs differ. The most-negative operand must be handled.
  - 9..15 illegal: EXEC path, result=0, err=1, flag_zero=1, flag_carry=0.
- err=0 for all legal ops. flag_zero is computed over the full 2*WIDTH result.
- busy=1 from the edge after accept through the HOLD cycle.

Decomposition:
- Shared package alu_hs_pkg: opcode localparams (OP_ADD..OP_MULS, OP_LAST=8), state encoding (IDLE, EXEC, MUL, HOLD).
- Sub-module alu_shift_add_mul: parameter WIDTH; ports clk, rst_n, start, signed_mode, a, b, done, product. Handles magnitude/sign-fix; done is a 1-cycle pulse on the final iteration.
- Top holds the FSM, operand latch, single-cycle ops and the output hold register.

Test Plan:
1. WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> out_valid 2 edges after accept, result=0x0100, flag_carry=1, flag_zero=0, err=0.
2. SUB a=0x03 b=0x05 -> result=0x00FE, flag_carry=1. SUB a=0x05 b=0x05 -> result=0x0000, flag_zero=1, flag_carry=0.
3. MUL a=0xFF b=0xFF -> result=0xFE01 exactly 9 edges after accept; busy=1 and in_ready=0 throughout; in_valid pulses mid-run are not accepted.
4. MULS a=0x80 b=0xFF -> 0x0080. MULS a=0x80 b=0x80 -> 0x4000. MULS a=0x7F b=0x80 -> 0xC080. SLT a=0x80 b=0x01 -> 1. SLTU a=0x80 b=0x01 -> 0.
5. Backpressure: ADD, then hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, out_valid=1, in_ready=0. Then out_ready=1 -> out_valid=0 and in_ready=1 after the next edge; back-to-back op accepted.
6. Illegal opcode 0xC -> err=1, result=0, flag_zero=1. Separately, assert rst_n=0 at the 4th MUL cycle -> all outputs 0 immediately, in_ready=1, and no out_valid for the aborted op after release.
